// File: rtl/ysyx_23060208_fetch_ctrl_if.sv
// rtl/ysyx_23060208_fetch_ctrl_if.sv - fetch controller PC, instruction bus, decoder and commit bundle
interface ysyx_23060208_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pc;
    logic                  pc_wen;
    logic [DATA_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;
    logic                  commit_valid;
    logic                  jump;
    logic [DATA_WIDTH-1:0] jump_target;
    logic                  trap;
    logic [DATA_WIDTH-1:0] mtvec;
    logic                  mret;
    logic [DATA_WIDTH-1:0] mepc;
    logic                  fetch_fault;

    modport master (
        input  pc,
        output pc_wen, next_pc,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output inst, inst_valid,
        input  inst_ready,
        input  commit_valid, jump, jump_target, trap, mtvec, mret, mepc,
        output fetch_fault
    );

    modport slave (
        output pc,
        input  pc_wen, next_pc,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  inst, inst_valid,
        output inst_ready,
        output commit_valid, jump, jump_target, trap, mtvec, mret, mepc,
        input  fetch_fault
    );
endinterface

// File: rtl/ysyx_23060208_fetch_ctrl.sv
// rtl/ysyx_23060208_fetch_ctrl.sv - instruction fetch FSM driving the PC register, read bus and decoder handshake
// Optional perf counters are enabled with `define YSYX_23060208_FETCH_PERF_EN.
module ysyx_23060208_fetch_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060208_fetch_ctrl_if.master bus
`ifdef YSYX_23060208_FETCH_PERF_EN
    ,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);
    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_in_boot;
    logic                  w_in_req;
    logic                  w_in_wait;
    logic                  w_in_out;
    logic                  w_in_exec;
    logic                  w_rd_ok;
    logic                  w_rd_err;
    logic                  w_commit;

    // Outputs are masked by rst so a transaction in flight is dropped in the reset cycle itself.
    assign w_in_boot = (r_state == S_BOOT) && !rst;
    assign w_in_req  = (r_state == S_REQ)  && !rst;
    assign w_in_wait = (r_state == S_WAIT) && !rst;
    assign w_in_out  = (r_state == S_OUT)  && !rst;
    assign w_in_exec = (r_state == S_EXEC) && !rst;

    assign w_rd_ok    = w_in_wait && bus.rvalid && (bus.rresp == 2'b00);
    assign w_rd_err   = w_in_wait && bus.rvalid && (bus.rresp != 2'b00);
    assign w_commit   = w_in_exec && bus.commit_valid;
    assign w_pc_plus4 = bus.pc + DATA_WIDTH'(4);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_rd_err) begin
            w_next_pc = bus.mtvec;
        end else if (w_commit) begin
            if (bus.trap) begin
                w_next_pc = bus.mtvec;
            end else if (bus.mret) begin
                w_next_pc = bus.mepc;
            end else if (bus.jump) begin
                w_next_pc = bus.jump_target;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT:  w_next_state = S_REQ;
            S_REQ:   if (bus.arready) w_next_state = S_WAIT;
            S_WAIT:  if (bus.rvalid) w_next_state = (bus.rresp == 2'b00) ? S_OUT : S_REQ;
            S_OUT:   if (bus.inst_ready) w_next_state = S_EXEC;
            S_EXEC:  if (bus.commit_valid) w_next_state = S_REQ;
            default: w_next_state = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_inst  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_rd_ok) begin
                r_inst <= bus.rdata;
            end
        end
    end

    // araddr tracks pc directly; pc cannot move while in REQ because pc_wen is low there.
    assign bus.pc_wen      = w_in_boot || w_rd_err || w_commit;
    assign bus.next_pc     = w_next_pc;
    assign bus.araddr      = bus.pc;
    assign bus.arvalid     = w_in_req;
    assign bus.rready      = w_in_wait;
    assign bus.inst        = r_inst;
    assign bus.inst_valid  = w_in_out;
    assign bus.fetch_fault = w_rd_err;

`ifdef YSYX_23060208_FETCH_PERF_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch_cnt <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (w_rd_ok) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_in_req || w_in_wait) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch_cnt;
    assign perf_stall_cnt = r_perf_stall_cnt;
`endif
endmodule

// File: tb/tb_ysyx_23060208_fetch_ctrl.sv
// tb/tb_ysyx_23060208_fetch_ctrl.sv - scoreboard bench for the fetch controller with a behavioural PC register
module tb_ysyx_23060208_fetch_ctrl;
    localparam int          DW    = 32;
    localparam logic [31:0] MTVEC = 32'h8000_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] exp_inst_q[$];
    logic [DW-1:0] exp_npc_q[$];

    always #5 clk = ~clk;

    ysyx_23060208_fetch_ctrl_if #(.DATA_WIDTH(DW)) bus ();

`ifdef YSYX_23060208_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    ysyx_23060208_fetch_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master)
`ifdef YSYX_23060208_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Behavioural PC register owned by the environment.
    always @(posedge clk) begin
        if (rst) bus.pc <= 32'h7FFF_FFFC;
        else if (bus.pc_wen) bus.pc <= bus.next_pc;
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.inst_ready = 1'b0; bus.commit_valid = 1'b0;
        bus.jump = 1'b0; bus.jump_target = '0; bus.trap = 1'b0; bus.mtvec = MTVEC;
        bus.mret = 1'b0; bus.mepc = '0;
    endtask

    task automatic serve_fetch(input logic [31:0] data, input logic [1:0] resp, input int ar_delay,
                               input int r_delay, output bit found, output logic [31:0] addr,
                               output bit stable, output bit excl, output bit fault, output bit fault_wen,
                               output logic [31:0] fault_npc, output bit fault_after);
        found = 0; addr = '0; stable = 1; excl = 1;
        fault = 0; fault_wen = 0; fault_npc = '0; fault_after = 0;
        for (int i = 0; i < 20 && !bus.arvalid; i++) next_cycle();
        if (!bus.arvalid) return;
        found = 1;
        addr = bus.araddr;
        for (int i = 0; i < ar_delay; i++) begin
            next_cycle();
            if (!bus.arvalid || bus.araddr !== addr) stable = 0;
        end
        bus.arready = 1'b1;
        next_cycle();
        bus.arready = 1'b0;
        #1;
        for (int i = 0; i <= r_delay; i++) begin
            if (!bus.rready || bus.arvalid || bus.inst_valid) excl = 0;
            if (i < r_delay) next_cycle();
        end
        bus.rvalid = 1'b1; bus.rdata = data; bus.rresp = resp;
        if (resp == 2'b00) exp_inst_q.push_back(data);
        #1;
        fault = bus.fetch_fault; fault_wen = bus.pc_wen; fault_npc = bus.next_pc;
        next_cycle();
        bus.rvalid = 1'b0; bus.rresp = 2'b00;
        #1;
        fault_after = bus.fetch_fault;
    endtask

    task automatic accept_inst(input int rdy_delay, output bit found, output logic [31:0] inst_o,
                               output bit held);
        found = 0; inst_o = '0; held = 1;
        for (int i = 0; i < 20 && !bus.inst_valid; i++) next_cycle();
        if (!bus.inst_valid) return;
        found = 1;
        inst_o = bus.inst;
        for (int i = 0; i < rdy_delay; i++) begin
            next_cycle();
            if (!bus.inst_valid || bus.inst !== inst_o || bus.arvalid || bus.rready) held = 0;
        end
        bus.inst_ready = 1'b1;
        next_cycle();
        bus.inst_ready = 1'b0;
        #1;
    endtask

    task automatic do_commit(input logic jmp, input logic [31:0] jt, input logic trp, input logic mr,
                             input logic [31:0] mep, output logic wen, output logic [31:0] npc);
        bus.commit_valid = 1'b1; bus.jump = jmp; bus.jump_target = jt;
        bus.trap = trp; bus.mret = mr; bus.mepc = mep;
        #1;
        wen = bus.pc_wen; npc = bus.next_pc;
        next_cycle();
        bus.commit_valid = 1'b0; bus.jump = 1'b0; bus.trap = 1'b0; bus.mret = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst = 1'b1;
        clear_inputs();
        repeat (3) next_cycle();
        checks++;
        if (bus.pc_wen !== 1'b0 || bus.arvalid !== 1'b0 || bus.rready !== 1'b0 ||
            bus.inst_valid !== 1'b0 || bus.fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: pc_wen=%b arvalid=%b rready=%b inst_valid=%b fetch_fault=%b expected all 0",
                     bus.pc_wen, bus.arvalid, bus.rready, bus.inst_valid, bus.fetch_fault);
        end
        checks++;
        if (bus.inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_inst: got %h expected 00000000", bus.inst);
        end
        exp_npc_q.push_back(32'h8000_0000);
        rst = 1'b0;
        #1;
        exp = exp_npc_q.pop_front();
        checks++;
        if (bus.pc_wen !== 1'b1 || bus.next_pc !== exp) begin
            failures++;
            $display("FAIL boot_pc_wen: pc_wen=%b next_pc=%h expected 1 %h", bus.pc_wen, bus.next_pc, exp);
        end
        next_cycle();
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0000 || bus.pc_wen !== 1'b0) begin
            failures++;
            $display("FAIL first_fetch: arvalid=%b araddr=%h pc_wen=%b expected 1 80000000 0",
                     bus.arvalid, bus.araddr, bus.pc_wen);
        end
    endtask

    task automatic test_delayed_handshake();
        bit found, stable, excl, fault, fwen, fafter, held;
        logic [31:0] addr, fnpc, inst, exp, npc;
        logic wen;
        serve_fetch(32'h0010_0093, 2'b00, 3, 2, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        checks++;
        if (!found || addr !== 32'h8000_0000 || !stable) begin
            failures++;
            $display("FAIL delayed_araddr: found=%b araddr=%h stable=%b expected 1 80000000 1", found, addr, stable);
        end
        checks++;
        if (!excl || fault || fwen) begin
            failures++;
            $display("FAIL delayed_wait: rready_excl=%b fault=%b pc_wen=%b expected 1 0 0", excl, fault, fwen);
        end
        bus.commit_valid = 1'b1; bus.trap = 1'b1;
        #1;
        checks++;
        if (bus.pc_wen !== 1'b0 || bus.inst_valid !== 1'b1) begin
            failures++;
            $display("FAIL commit_in_out: pc_wen=%b inst_valid=%b expected 0 1", bus.pc_wen, bus.inst_valid);
        end
        bus.commit_valid = 1'b0; bus.trap = 1'b0;
        accept_inst(3, found, inst, held);
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hXXXX_XXXX;
        checks++;
        if (!found || inst !== exp || !held) begin
            failures++;
            $display("FAIL delayed_inst: found=%b inst=%h held=%b expected 1 %h 1", found, inst, held, exp);
        end
        bus.trap = 1'b1; bus.jump = 1'b1;
        #1;
        checks++;
        if (bus.pc_wen !== 1'b0 || bus.inst_valid !== 1'b0 || bus.arvalid !== 1'b0) begin
            failures++;
            $display("FAIL exec_idle: pc_wen=%b inst_valid=%b arvalid=%b expected 0 0 0",
                     bus.pc_wen, bus.inst_valid, bus.arvalid);
        end
        bus.trap = 1'b0; bus.jump = 1'b0;
        next_cycle();
        exp_npc_q.push_back(32'h8000_0004);
        do_commit(1'b0, '0, 1'b0, 1'b0, '0, wen, npc);
        exp = exp_npc_q.pop_front();
        checks++;
        if (wen !== 1'b1 || npc !== exp) begin
            failures++;
            $display("FAIL commit_seq: pc_wen=%b next_pc=%h expected 1 %h", wen, npc, exp);
        end
    endtask

    task automatic test_redirect_priority();
        bit found, stable, excl, fault, fwen, fafter, held;
        logic [31:0] addr, fnpc, inst, exp, npc;
        logic wen;
        serve_fetch(32'h0000_0073, 2'b00, 0, 0, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        accept_inst(0, found, inst, held);
        exp = exp_inst_q.pop_front();
        checks++;
        if (addr !== 32'h8000_0004 || inst !== exp) begin
            failures++;
            $display("FAIL trap_fetch: araddr=%h inst=%h expected 80000004 %h", addr, inst, exp);
        end
        exp_npc_q.push_back(MTVEC);
        do_commit(1'b1, 32'h8000_0100, 1'b1, 1'b0, '0, wen, npc);
        exp = exp_npc_q.pop_front();
        checks++;
        if (wen !== 1'b1 || npc !== exp) begin
            failures++;
            $display("FAIL trap_over_jump: pc_wen=%b next_pc=%h expected 1 %h", wen, npc, exp);
        end
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== MTVEC || bus.pc_wen !== 1'b0) begin
            failures++;
            $display("FAIL issue_latency: arvalid=%b araddr=%h pc_wen=%b expected 1 %h 0",
                     bus.arvalid, bus.araddr, bus.pc_wen, MTVEC);
        end
        serve_fetch(32'h3020_0073, 2'b00, 1, 0, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        accept_inst(1, found, inst, held);
        exp = exp_inst_q.pop_front();
        checks++;
        if (inst !== exp || !held) begin
            failures++;
            $display("FAIL mret_inst: inst=%h held=%b expected %h 1", inst, held, exp);
        end
        exp_npc_q.push_back(32'h8000_0200);
        do_commit(1'b1, 32'h8000_0300, 1'b0, 1'b1, 32'h8000_0200, wen, npc);
        exp = exp_npc_q.pop_front();
        checks++;
        if (wen !== 1'b1 || npc !== exp) begin
            failures++;
            $display("FAIL mret_over_jump: pc_wen=%b next_pc=%h expected 1 %h", wen, npc, exp);
        end
        serve_fetch(32'h0000_006F, 2'b00, 0, 1, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        accept_inst(0, found, inst, held);
        void'(exp_inst_q.pop_front());
        exp_npc_q.push_back(32'hFFFF_FFFC);
        do_commit(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h1234_5678, wen, npc);
        exp = exp_npc_q.pop_front();
        checks++;
        if (addr !== 32'h8000_0200 || wen !== 1'b1 || npc !== exp) begin
            failures++;
            $display("FAIL jump_commit: araddr=%h pc_wen=%b next_pc=%h expected 80000200 1 %h", addr, wen, npc, exp);
        end
    endtask

    task automatic test_wrap();
        bit found, stable, excl, fault, fwen, fafter, held;
        logic [31:0] addr, fnpc, inst, exp, npc;
        logic wen;
        serve_fetch(32'h0000_0013, 2'b00, 0, 0, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        accept_inst(0, found, inst, held);
        void'(exp_inst_q.pop_front());
        exp_npc_q.push_back(32'h0000_0000);
        do_commit(1'b0, '0, 1'b0, 1'b0, '0, wen, npc);
        exp = exp_npc_q.pop_front();
        checks++;
        if (addr !== 32'hFFFF_FFFC || wen !== 1'b1 || npc !== exp) begin
            failures++;
            $display("FAIL pc_wrap: araddr=%h pc_wen=%b next_pc=%h expected FFFFFFFC 1 %h", addr, wen, npc, exp);
        end
    endtask

    task automatic test_fetch_fault();
        bit found, stable, excl, fault, fwen, fafter;
        logic [31:0] addr, fnpc;
        int qsize;
        qsize = exp_inst_q.size();
        serve_fetch(32'hBAD0_BAD0, 2'b10, 1, 1, found, addr, stable, excl, fault, fwen, fnpc, fafter);
        checks++;
        if (addr !== 32'h0000_0000 || fault !== 1'b1 || fwen !== 1'b1 || fnpc !== MTVEC) begin
            failures++;
            $display("FAIL fault_redirect: araddr=%h fault=%b pc_wen=%b next_pc=%h expected 00000000 1 1 %h",
                     addr, fault, fwen, fnpc, MTVEC);
        end
        checks++;
        if (fafter !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pc_wen !== 1'b0) begin
            failures++;
            $display("FAIL fault_pulse: fault_next=%b inst_valid=%b pc_wen=%b expected 0 0 0",
                     fafter, bus.inst_valid, bus.pc_wen);
        end
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== MTVEC || exp_inst_q.size() != qsize) begin
            failures++;
            $display("FAIL fault_refetch: arvalid=%b araddr=%h expected 1 %h", bus.arvalid, bus.araddr, MTVEC);
        end
    endtask

    task automatic test_reset_in_wait();
        bus.arready = 1'b1;
        next_cycle();
        bus.arready = 1'b0;
        #1;
        checks++;
        if (bus.rready !== 1'b1) begin
            failures++;
            $display("FAIL wait_rready: got %b expected 1", bus.rready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rready !== 1'b0 || bus.arvalid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pc_wen !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_wait: rready=%b arvalid=%b inst_valid=%b pc_wen=%b expected 0 0 0 0",
                     bus.rready, bus.arvalid, bus.inst_valid, bus.pc_wen);
        end
        next_cycle();
        rst = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b00;
        #1;
        checks++;
        if (bus.pc_wen !== 1'b1 || bus.next_pc !== 32'h8000_0000 || bus.rready !== 1'b0 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_reboot: pc_wen=%b next_pc=%h rready=%b inst_valid=%b expected 1 80000000 0 0",
                     bus.pc_wen, bus.next_pc, bus.rready, bus.inst_valid);
        end
        next_cycle();
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0000 || bus.rready !== 1'b0 ||
            bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) begin
            failures++;
            $display("FAIL rst_stale_resp: arvalid=%b araddr=%h rready=%b inst_valid=%b inst=%h expected 1 80000000 0 0 0",
                     bus.arvalid, bus.araddr, bus.rready, bus.inst_valid, bus.inst);
        end
        bus.rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit found, stable, excl, fault, fwen, fafter, held;
        logic [31:0] addr, fnpc, inst, exp, npc, exp_pc, data;
        logic wen;
        exp_pc = 32'h8000_0000;
        for (int n = 0; n < 4; n++) begin
            data = $urandom;
            serve_fetch(data, 2'b00, 0, 0, found, addr, stable, excl, fault, fwen, fnpc, fafter);
            checks++;
            if (!found || addr !== exp_pc || !excl) begin
                failures++;
                $display("FAIL b2b_addr[%0d]: found=%b araddr=%h excl=%b expected 1 %h 1", n, found, addr, excl, exp_pc);
            end
            accept_inst(0, found, inst, held);
            exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hXXXX_XXXX;
            checks++;
            if (!found || inst !== exp) begin
                failures++;
                $display("FAIL b2b_inst[%0d]: found=%b inst=%h expected 1 %h", n, found, inst, exp);
            end
            exp_npc_q.push_back(exp_pc + 32'd4);
            do_commit(1'b0, '0, 1'b0, 1'b0, '0, wen, npc);
            exp = exp_npc_q.pop_front();
            checks++;
            if (wen !== 1'b1 || npc !== exp) begin
                failures++;
                $display("FAIL b2b_npc[%0d]: pc_wen=%b next_pc=%h expected 1 %h", n, wen, npc, exp);
            end
            exp_pc = exp_pc + 32'd4;
        end
        checks++;
        if (exp_inst_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d instructions left expected 0", exp_inst_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_delayed_handshake();
        test_redirect_priority();
        test_wrap();
        test_fetch_fault();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_23060208_fetch_ctrl.md
YSYX_23060208_FETCH_CTRL -- requirements
Module: ysyx_23060208_fetch_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of PC, addresses and instruction words.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pc  in  DATA_WIDTH  current PC from the PC register.
REQ-005 pc_wen  out  1  PC register write enable.
REQ-006 next_pc  out  DATA_WIDTH  value written to the PC register when pc_wen=1.
REQ-007 araddr / arvalid / arready  out / out / in  DATA_WIDTH / 1 / 1  instruction read-address channel.
REQ-008 rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  instruction read-data channel.
REQ-009 inst / inst_valid / inst_ready  out / out / in  DATA_WIDTH / 1 / 1  instruction handed to the decoder.
REQ-010 commit_valid  in  1  the current instruction has finished executing.
REQ-011 jump, jump_target / trap, mtvec / mret, mepc  in  1 / DATA_WIDTH each pair  redirect requests qualified by commit_valid.
REQ-012 fetch_fault  out  1  one-cycle pulse on a fetch bus error.

Function
REQ-013 FSM states SHALL be BOOT, REQ, WAIT, OUT, EXEC.
REQ-014 BOOT: pc_wen=1 and next_pc=pc+4 for exactly one cycle, then REQ. The PC register resets to 0x7FFF_FFFC, so the first fetch is at 0x8000_0000.
REQ-015 REQ: arvalid=1 and araddr=pc; araddr SHALL stay stable until arready. On arvalid&arready, go to WAIT.
REQ-016 WAIT: rready=1. On rvalid with rresp==0, latch rdata into inst and go to OUT.
REQ-017 WAIT: on rvalid with rresp!=0, pulse fetch_fault, set pc_wen=1 with next_pc=mtvec, and go to REQ. No instruction is issued.
REQ-018 OUT: inst_valid=1 and inst held stable until inst_ready. On inst_valid&inst_ready, go to EXEC.
REQ-019 EXEC: wait for commit_valid. On commit_valid, pc_wen=1 for one cycle, then REQ.
REQ-020 next_pc selection priority: trap→mtvec, else mret→mepc, else jump→jump_target, else pc+4.
REQ-021 pc+4 SHALL wrap modulo 2^DATA_WIDTH (0xFFFF_FFFC+4 → 0x0000_0000).
REQ-022 pc_wen SHALL be 0 in every cycle not named in REQ-014, REQ-017 and REQ-019.
REQ-023 Redirect inputs SHALL be ignored when commit_valid=0 or the FSM is not in EXEC.
REQ-024 commit_valid seen outside EXEC SHALL be ignored.
REQ-025 arvalid, rready and inst_valid SHALL be mutually exclusive.
REQ-026 fetch-to-issue latency: arvalid SHALL assert in the cycle after pc_wen.

Reset
REQ-027 On rst, the FSM SHALL go to BOOT.
REQ-028 Reset values: arvalid=0, rready=0, inst_valid=0, inst=0, fetch_fault=0, pc_wen=0.
REQ-029 Reset asserted in any state SHALL abort the transaction. Read responses arriving after reset SHALL be ignored until a new REQ.

Configuration
REQ-030 Macro YSYX_23060208_FETCH_PERF_EN defined: add outputs perf_fetch_cnt (32 bits) and perf_stall_cnt (32 bits).
- perf_fetch_cnt increments on each successful rvalid&rready with rresp==0.
- perf_stall_cnt increments on each cycle spent in REQ or WAIT.
- Both counters reset to 0 and wrap at 2^32.
REQ-031 Macro undefined: neither port nor the counter logic SHALL exist, and behaviour is otherwise identical.

Verification
REQ-032 Release reset with pc=0x7FFF_FFFC → one pc_wen with next_pc=0x8000_0000, then arvalid with araddr=0x8000_0000.
REQ-033 arready delayed 3 cycles, rvalid delayed 2 cycles → araddr stable throughout; inst=rdata; inst_valid held until inst_ready.
REQ-034 commit_valid with jump=1, jump_target=0x8000_0100, trap=1, mtvec=0x8000_0040 → next_pc=0x8000_0040.
REQ-035 rresp=2'b10 on a fetch → fetch_fault pulse for 1 cycle, next_pc=mtvec, no inst_valid.
REQ-036 pc=0xFFFF_FFFC with no redirect at commit → next_pc=0x0000_0000.
REQ-037 rst asserted in WAIT, then rvalid → rready=0 and no inst_valid; the FSM re-enters BOOT.
